// File: rtl/hex_scroll_pkg.sv
// Shared types, widths and window indexing for the six-digit scrolling marquee.
package hex_scroll_pkg;

  localparam int unsigned CHAR_W     = 5;
  localparam int unsigned MSG_DEPTH  = 32;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned LEN_W      = 6;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned RATE_W     = 2;
  localparam int unsigned CNT_W      = 32;

  localparam logic [CHAR_W-1:0] BLANK_CODE = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    SCROLL,
    PAUSE
  } state_e;

  // Message index shown on a digit: (ptr + digit) mod len, valid while ptr < len and digit < len.
  function automatic logic [IDX_W-1:0] win_idx(
    input logic [IDX_W-1:0]   ptr,
    input logic [DIGIT_W-1:0] digit,
    input logic [LEN_W-1:0]   len
  );
    logic [LEN_W:0] sum;
    sum = (LEN_W+1)'(ptr) + (LEN_W+1)'(digit);
    if (sum >= (LEN_W+1)'(len)) begin
      sum = sum - (LEN_W+1)'(len);
    end
    return IDX_W'(sum);
  endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// Scroll-step timebase: one-cycle tick every BASE_TICK_DIV << rate_sel clocks while enabled.
module scroll_prescaler
  import hex_scroll_pkg::*;
#(
  parameter int unsigned BASE_TICK_DIV = 12500000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate_sel,
  output logic              tick_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] period_m1;

  assign period_m1 = (CNT_W'(BASE_TICK_DIV) << rate_sel) - CNT_W'(1);

  // Compare with >= so that lowering rate_sel below the running count ticks at once.
  assign tick_c = enable && !clear && (count_q >= period_m1);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!enable || clear || tick_c) begin
      count_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Marquee scheduler: message store, run/stop/direction FSM and the registered
// six-digit character window for the seven-segment decoders.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int unsigned BASE_TICK_DIV = 12500000,
  parameter int unsigned PAUSE_STEPS   = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_addr,
  input  logic [CHAR_W-1:0]            wr_data,
  input  logic [LEN_W-1:0]             msg_len,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         dir,
  input  logic [RATE_W-1:0]            rate_sel,
  output logic                         display,
  output logic [NUM_DIGITS*CHAR_W-1:0] chars,
  output logic                         busy,
  output logic                         wrap
);

  localparam int unsigned PAUSE_W = $clog2(PAUSE_STEPS + 1);

  logic [CHAR_W-1:0]            msg_q [MSG_DEPTH];
  state_e                       state_q;
  logic [LEN_W-1:0]             len_q;
  logic [IDX_W-1:0]             ptr_q;
  logic [IDX_W-1:0]             ptr_nxt;
  logic [LEN_W-1:0]             ptr_inc;
  logic [PAUSE_W-1:0]           pause_q;
  logic                         dir_q;
  logic                         wrap_q;
  logic                         busy_q;
  logic                         display_q;
  logic [NUM_DIGITS*CHAR_W-1:0] chars_q;
  logic [NUM_DIGITS*CHAR_W-1:0] chars_d;
  logic                         start_ok;
  logic                         tick;
  logic                         pre_en;
  logic                         pre_clr;

  // Starts with an out-of-range length are dropped entirely.
  assign start_ok = start && (msg_len != '0) && (msg_len <= LEN_W'(MSG_DEPTH));
  assign pre_en   = (state_q != IDLE);
  assign pre_clr  = stop || start_ok;

  scroll_prescaler #(
    .BASE_TICK_DIV(BASE_TICK_DIV)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .enable  (pre_en),
    .clear   (pre_clr),
    .rate_sel(rate_sel),
    .tick_c  (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
        msg_q[i] <= BLANK_CODE;
      end
    end else if (wr_en) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  // Pointer after one scroll step in the latched direction.
  assign ptr_inc = LEN_W'(ptr_q) + LEN_W'(1);

  always_comb begin
    ptr_nxt = '0;
    if (!dir_q) begin
      ptr_nxt = (ptr_inc >= len_q) ? '0 : IDX_W'(ptr_inc);
    end else begin
      ptr_nxt = (ptr_q == '0) ? IDX_W'(len_q - LEN_W'(1)) : ptr_q - IDX_W'(1);
    end
  end

  // Control precedence: stop, then start, then prescaler tick.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      pause_q <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        pause_q <= '0;
        busy_q  <= 1'b0;
      end else if (start_ok) begin
        len_q   <= msg_len;
        dir_q   <= dir;
        ptr_q   <= '0;
        pause_q <= '0;
        busy_q  <= 1'b1;
        state_q <= (msg_len <= LEN_W'(NUM_DIGITS)) ? SHOW : SCROLL;
      end else if (tick) begin
        case (state_q)
          SCROLL: begin
            ptr_q <= ptr_nxt;
            if (ptr_nxt == '0) begin
              wrap_q  <= 1'b1;
              pause_q <= '0;
              state_q <= PAUSE;
            end
          end
          PAUSE: begin
            if (pause_q == PAUSE_W'(PAUSE_STEPS - 1)) begin
              state_q <= SCROLL;
            end else begin
              pause_q <= pause_q + PAUSE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Window contents for the current state; leftmost digit in the top bits.
  always_comb begin
    chars_d = {NUM_DIGITS{BLANK_CODE}};
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (state_q == SHOW) begin
        if (LEN_W'(i) < len_q) begin
          chars_d[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = msg_q[IDX_W'(i)];
        end
      end else if ((state_q == SCROLL) || (state_q == PAUSE)) begin
        chars_d[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = msg_q[win_idx(ptr_q, DIGIT_W'(i), len_q)];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      display_q <= 1'b0;
      chars_q   <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      display_q <= (state_q != IDLE);
      chars_q   <= chars_d;
    end
  end

  assign display = display_q;
  assign chars   = chars_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;

endmodule
